ppu_sparse_encoder: RTL and testbench



---
 rtl/ppu_sparse_encoder_if.sv | 28 ++
 rtl/ppu_sparse_encoder.sv | 213 +++++++++++++++++++++
 tb/tb_ppu_sparse_encoder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_sparse_encoder_if.sv
// Sparse entry stream from the PPU encoder to the activation RAM.
// Valid/ready handshake carrying (value, zero-run, last) entries.
interface ppu_sparse_encoder_if #(
    parameter int DATA_W = 16,
    parameter int RUN_W  = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_value;
    logic [RUN_W-1:0]  out_run;
    logic              out_last;

    modport master (
        output out_valid,
        output out_value,
        output out_run,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_value,
        input  out_run,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ppu_sparse_encoder.sv
// Row FIFO plus lane scanner emitting (value, zero-run) sparse pairs.
// Define PPU_RELU_EN to treat negative lane values as zero.
module ppu_sparse_encoder #(
    parameter int BANKS     = 8,
    parameter int DATA_W    = 16,
    parameter int RUN_W     = 4,
    parameter int ROW_DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    drain_start,
    input  logic [7:0]              cfg_rows,
    input  logic [BANKS-1:0]        in_valid,
    input  logic [BANKS*DATA_W-1:0] in_data,
    ppu_sparse_encoder_if.master    out_if,
    output logic                    PPU_finish_en,
    output logic                    err_overflow
);

    localparam int AW = $clog2(ROW_DEPTH);
    localparam int LW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [LW-1:0] LANE_LAST = LW'(BANKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        TERM,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       rows_cfg_q;
    logic [7:0]       rows_in_q;
    logic [7:0]       rows_done_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic [LW-1:0]    lane_q;
    logic [AW:0]      wptr_q, rptr_q;

    logic              vld_q;
    logic [DATA_W-1:0] val_q;
    logic [RUN_W-1:0]  run_o_q;
    logic              last_q;
    logic              fin_q;
    logic              err_q;

    logic [BANKS-1:0]        mem_v [ROW_DEPTH];
    logic [BANKS*DATA_W-1:0] mem_d [ROW_DEPTH];

    logic [BANKS-1:0]        head_v;
    logic [BANKS*DATA_W-1:0] head_d;
    logic                    lane_v;
    logic [DATA_W-1:0]       lane_d;
    logic                    lane_zero;

    logic fifo_empty;
    logic fifo_full;
    logic out_free;
    logic scan;
    logic pop;
    logic push_req;
    logic push;
    logic ovf;
    logic all_done;

    logic              emit;
    logic [DATA_W-1:0] emit_val;
    logic [RUN_W-1:0]  emit_run;
    logic              emit_last;

    // Scanner reads the FIFO head directly, so lane 0 is seen one cycle after push
    assign head_v = mem_v[rptr_q[AW-1:0]];
    assign head_d = mem_d[rptr_q[AW-1:0]];
    assign lane_v = head_v[lane_q];
    assign lane_d = head_d[int'(lane_q)*DATA_W +: DATA_W];

`ifdef PPU_RELU_EN
    assign lane_zero = (lane_d == '0) || lane_d[DATA_W-1];
`else
    assign lane_zero = (lane_d == '0);
`endif

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign out_free = !vld_q || out_if.out_ready;
    assign scan     = (state_q == RUN) && !fifo_empty && out_free;
    assign pop      = scan && (lane_q == LANE_LAST);
    assign push_req = (state_q == RUN) && (|in_valid);
    // A pop in the same cycle frees the slot a full FIFO needs
    assign push     = push_req && (rows_in_q != rows_cfg_q) &&
                      (!fifo_full || pop);
    assign ovf      = push_req && !push;
    assign all_done = (rows_done_q == rows_cfg_q);

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        emit      = 1'b0;
        emit_val  = '0;
        emit_run  = '0;
        emit_last = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (drain_start) state_d = RUN;
            end
            RUN: begin
                if (all_done && out_free) begin
                    state_d = TERM;
                end else if (scan && lane_v) begin
                    if (!lane_zero) begin
                        emit     = 1'b1;
                        emit_val = lane_d;
                        emit_run = run_q;
                        run_d    = '0;
                    end else if (run_q == RUN_MAX) begin
                        emit     = 1'b1;
                        emit_run = RUN_MAX;
                        run_d    = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
            end
            TERM: begin
                if (!vld_q) begin
                    emit      = 1'b1;
                    emit_run  = run_q;
                    emit_last = 1'b1;
                end else if (out_if.out_ready) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rows_cfg_q  <= '0;
            rows_in_q   <= '0;
            rows_done_q <= '0;
            run_q       <= '0;
            lane_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            vld_q       <= 1'b0;
            val_q       <= '0;
            run_o_q     <= '0;
            last_q      <= 1'b0;
            fin_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            fin_q   <= (state_d == FINISH);
            if (ovf) err_q <= 1'b1;

            if (emit) begin
                vld_q   <= 1'b1;
                val_q   <= emit_val;
                run_o_q <= emit_run;
                last_q  <= emit_last;
            end else if (out_if.out_ready) begin
                vld_q  <= 1'b0;
                last_q <= 1'b0;
            end

            if (state_q == IDLE) begin
                rows_cfg_q  <= cfg_rows;
                rows_in_q   <= '0;
                rows_done_q <= '0;
                run_q       <= '0;
                lane_q      <= '0;
                wptr_q      <= '0;
                rptr_q      <= '0;
            end else begin
                run_q <= run_d;
                if (push) begin
                    wptr_q    <= wptr_q + 1'b1;
                    rows_in_q <= rows_in_q + 1'b1;
                end
                if (scan) lane_q <= pop ? '0 : lane_q + 1'b1;
                if (pop) begin
                    rptr_q      <= rptr_q + 1'b1;
                    rows_done_q <= rows_done_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_v[wptr_q[AW-1:0]] <= in_valid;
            mem_d[wptr_q[AW-1:0]] <= in_data;
        end
    end

    assign out_if.out_valid = vld_q;
    assign out_if.out_value = val_q;
    assign out_if.out_run   = run_o_q;
    assign out_if.out_last  = last_q;
    assign PPU_finish_en    = fin_q;
    assign err_overflow     = err_q;

endmodule

// File: tb/tb_ppu_sparse_encoder.sv
// Directed and randomized checks of ppu_sparse_encoder against a
// queue-based model of the sparse (value, run) encoding rules.
module tb_ppu_sparse_encoder;

    localparam int BANKS     = 4;
    localparam int DATA_W    = 16;
    localparam int RUN_W     = 4;
    localparam int ROW_DEPTH = 4;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  run;
        logic        last;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drain_start = 1'b0;
    logic [7:0]  cfg_rows = '0;
    logic [3:0]  in_valid = '0;
    logic [63:0] in_data = '0;
    logic        fin;
    logic        err;

    ppu_sparse_encoder_if #(.DATA_W(DATA_W), .RUN_W(RUN_W)) oif ();

    ppu_sparse_encoder #(
        .BANKS(BANKS),
        .DATA_W(DATA_W),
        .RUN_W(RUN_W),
        .ROW_DEPTH(ROW_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .drain_start(drain_start),
        .cfg_rows(cfg_rows),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_if(oif),
        .PPU_finish_en(fin),
        .err_overflow(err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   fin_cnt = 0;
    bit   rand_ready = 1'b0;
    bit   ready_val = 1'b1;
    bit   hold = 1'b0;
    ent_t held;
    ent_t got_q[$];
    ent_t exp_q[$];

    logic [3:0]  rows_v [16];
    logic [15:0] rows_d [16][4];

    function automatic ent_t cur();
        return {oif.out_value, oif.out_run, oif.out_last};
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_zero(input logic [15:0] v);
`ifdef PPU_RELU_EN
        return (v == 16'd0) || v[15];
`else
        return (v == 16'd0);
`endif
    endfunction

    // Reference: walk valid lanes in order, counting zeros between values
    task automatic build_exp(input int n);
        int run;
        exp_q.delete();
        run = 0;
        for (int r = 0; r < n; r++) begin
            for (int l = 0; l < BANKS; l++) begin
                if (rows_v[r][l]) begin
                    if (!is_zero(rows_d[r][l])) begin
                        exp_q.push_back({rows_d[r][l], 4'(run), 1'b0});
                        run = 0;
                    end else if (run == 15) begin
                        exp_q.push_back({16'd0, 4'd15, 1'b0});
                        run = 0;
                    end else begin
                        run++;
                    end
                end
            end
        end
        exp_q.push_back({16'd0, 4'(run), 1'b1});
    endtask

    task automatic drive_rows(input int n, input int gap);
        for (int r = 0; r < n; r++) begin
            in_valid = rows_v[r];
            for (int l = 0; l < BANKS; l++)
                in_data[l*16 +: 16] = rows_d[r][l];
            tick();
            in_valid = '0;
            in_data = '0;
            repeat (gap) tick();
        end
    endtask

    task automatic start_drain(input int n);
        got_q.delete();
        fin_cnt = 0;
        cfg_rows = 8'(n);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
    endtask

    task automatic finish_and_compare(input string tag);
        int i;
        int n;
        for (i = 0; i < 3000; i++) begin
            if (fin_cnt > 0) break;
            tick();
        end
        check({tag, "_finish_seen"}, 32'(fin_cnt > 0), 32'd1);
        repeat (3) tick();
        check({tag, "_finish_once"}, 32'(fin_cnt), 32'd1);
        check({tag, "_idle_valid"}, 32'(oif.out_valid), 32'd0);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s_entry%0d", tag, k),
                  32'(got_q[k]), 32'(exp_q[k]));
    endtask

    task automatic run_drain(input string tag, input int n, input int gap);
        build_exp(n);
        start_drain(n);
        drive_rows(n, gap);
        finish_and_compare(tag);
    endtask

    task automatic set_row(input int r, input logic [3:0] v,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3);
        rows_v[r] = v;
        rows_d[r][0] = d0;
        rows_d[r][1] = d1;
        rows_d[r][2] = d2;
        rows_d[r][3] = d3;
    endtask

    initial begin
        oif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            oif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold = 1'b0;
            end else begin
                if (hold)
                    check("hold_stable", 32'({oif.out_valid, cur()}),
                          32'({1'b1, held}));
                if (oif.out_valid && oif.out_ready) got_q.push_back(cur());
                if (fin) fin_cnt++;
                hold = oif.out_valid && !oif.out_ready;
                held = cur();
            end
        end
    end

    initial begin
        int n;
        int w;
        #1 rst = 1'b0;
        #1;
        check("rst_valid", 32'(oif.out_valid), 32'd0);
        check("rst_value", 32'(oif.out_value), 32'd0);
        check("rst_run", 32'(oif.out_run), 32'd0);
        check("rst_last", 32'(oif.out_last), 32'd0);
        check("rst_finish", 32'(fin), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        set_row(0, 4'hF, 16'd5, 16'd0, 16'd0, 16'd7);
        set_row(1, 4'hF, 16'd0, 16'd0, 16'd0, 16'd0);
        run_drain("basic", 2, 0);
        if (got_q.size() > 1)
            check("basic_lit1", 32'(got_q[1]), 32'({16'd7, 4'd2, 1'b0}));

        for (int r = 0; r < 4; r++) set_row(r, 4'hF, 0, 0, 0, 0);
        set_row(4, 4'b0011, 16'd0, 16'd3, 16'hBEEF, 16'h1234);
        run_drain("run_sat", 5, 0);
        check("run_sat_no_ovf", 32'(err), 32'd0);

        set_row(0, 4'b1001, 16'd9, 16'hAAAA, 16'h5555, 16'd4);
        run_drain("invalid", 1, 0);

        set_row(0, 4'hF, 16'd5, 16'd0, 16'd0, 16'd7);
        set_row(1, 4'hF, 16'd0, 16'd0, 16'd0, 16'd0);
        build_exp(2);
        ready_val = 1'b0;
        start_drain(2);
        drive_rows(2, 0);
        for (w = 0; w < 50; w++) begin
            if (oif.out_valid) break;
            tick();
        end
        check("stall_valid_seen", 32'(oif.out_valid), 32'd1);
        repeat (5) tick();
        check("stall_none_lost", 32'(got_q.size()), 32'd0);
        ready_val = 1'b1;
        finish_and_compare("stall");

        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(0, 4);
            for (int r = 0; r < n; r++) begin
                rows_v[r] = 4'($urandom_range(0, 15));
                if (rows_v[r] == 4'd0) rows_v[r] = 4'd1;
                for (int l = 0; l < BANKS; l++) begin
                    if ($urandom_range(0, 9) < 7) rows_d[r][l] = 16'd0;
                    else rows_d[r][l] = 16'($urandom);
                end
            end
            rand_ready = 1'b1;
            run_drain($sformatf("rand%0d", it), n, $urandom_range(0, 3));
            rand_ready = 1'b0;
        end
        check("rand_no_ovf", 32'(err), 32'd0);

        for (int r = 0; r < 8; r++) set_row(r, 4'hF, 1, 1, 1, 1);
        ready_val = 1'b0;
        start_drain(8);
        drive_rows(8, 0);
        check("ovf_set", 32'(err), 32'd1);
        repeat (20) tick();
        check("ovf_sticky", 32'(err), 32'd1);
        check("ovf_no_finish", 32'(fin_cnt), 32'd0);
        check("ovf_pending", 32'(oif.out_valid), 32'd1);

        rst = 1'b0;
        #1;
        check("abort_valid", 32'(oif.out_valid), 32'd0);
        check("abort_value", 32'(oif.out_value), 32'd0);
        check("abort_last", 32'(oif.out_last), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_finish", 32'(fin), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        ready_val = 1'b1;
        tick();
        run_drain("zero_rows", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
